// File: rtl/uart_tx_module.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a start/data/stop serialiser.
// The serial line, done pulse and busy flag are all registered so the line never glitches.
module uart_tx_module #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Pin_Out,
  output logic       TX_Full,
  output logic       TX_Busy,
  output logic       TX_Done_Sig,
  output logic       TX_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            pin_q, pin_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ovf_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;

  logic            wr_ok, wr_ovf, pop, terminal;

  // Acceptance looks only at the start-of-cycle count, so a same-cycle pop cannot rescue a full write.
  assign wr_ok    = TX_En_Sig && (count_q < CW'(FIFO_DEPTH));
  assign wr_ovf   = TX_En_Sig && !wr_ok;
  assign terminal = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign busy_d   = (state_q != IDLE) || (count_q != '0);

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wptr_q] <= TX_Data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_ovf) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pin_d   = pin_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          timer_d = '0;
          state_d = START;
          pin_d   = 1'b0;
        end
      end
      START: begin
        if (terminal) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
          pin_d   = shift_q[0];
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (terminal) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            pin_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            pin_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        pin_d = 1'b1;
        if (terminal) begin
          timer_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      pin_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      pin_q   <= pin_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  assign TX_Pin_Out  = pin_q;
  assign TX_Full     = (count_q == CW'(FIFO_DEPTH));
  assign TX_Busy     = busy_q;
  assign TX_Done_Sig = done_q;
  assign TX_Overflow = ovf_q;

endmodule
